// File: rtl/vga_timing.sv
// Shared 640x480@60 timing constants and ball-update FSM encoding.
// Used by vga_sync, vblank_detect and frame_step_scheduler.
package vga_timing;

  localparam int H_ACTIVE = 640;
  localparam int H_TOTAL  = 800;
  localparam int V_ACTIVE = 480;
  localparam int V_TOTAL  = 525;
  localparam int CW       = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    COMMIT = 2'd2,
    WAIT   = 2'd3
  } fss_state_t;

endpackage

// File: rtl/vblank_detect.sv
// Registered one-clk vblank_start / frame_start pulses from vga_sync counts.
// In: clk, reset_n, p_tick, pixel_x, pixel_y. Out: vblank_start, frame_start.
module vblank_detect #(
  parameter int H_TOTAL  = vga_timing::H_TOTAL,
  parameter int V_TOTAL  = vga_timing::V_TOTAL,
  parameter int V_ACTIVE = vga_timing::V_ACTIVE
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      p_tick,
  input  logic [vga_timing::CW-1:0] pixel_x,
  input  logic [vga_timing::CW-1:0] pixel_y,
  output logic                      vblank_start,
  output logic                      frame_start
);

  localparam int CW = vga_timing::CW;

  logic line_end;
  assign line_end = p_tick && (pixel_x == CW'(H_TOTAL - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vblank_start <= 1'b0;
      frame_start  <= 1'b0;
    end else begin
      vblank_start <= line_end && (pixel_y == CW'(V_ACTIVE - 1));
      frame_start  <= line_end && (pixel_y == CW'(V_TOTAL - 1));
    end
  end

endmodule

// File: rtl/frame_step_scheduler.sv
// Tear-free ball update: one physics step per STEP_DIV vblanks, committed in blanking.
// In: clk, reset_n, p_tick, pixel_x/y, enable, step_ack, new_x/y. Out: step_req, ball_x/y, frame_cnt, overrun, busy.
module frame_step_scheduler #(
  parameter int H_TOTAL  = vga_timing::H_TOTAL,
  parameter int V_TOTAL  = vga_timing::V_TOTAL,
  parameter int V_ACTIVE = vga_timing::V_ACTIVE,
  parameter int STEP_DIV = 1,
  parameter int INIT_X   = 320,
  parameter int INIT_Y   = 240
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      p_tick,
  input  logic [vga_timing::CW-1:0] pixel_x,
  input  logic [vga_timing::CW-1:0] pixel_y,
  input  logic                      enable,
  input  logic                      step_ack,
  input  logic [vga_timing::CW-1:0] new_x,
  input  logic [vga_timing::CW-1:0] new_y,
  output logic                      step_req,
  output logic [vga_timing::CW-1:0] ball_x,
  output logic [vga_timing::CW-1:0] ball_y,
  output logic [15:0]               frame_cnt,
  output logic                      overrun,
  output logic                      busy
);

  import vga_timing::*;

  logic          vblank_start;
  logic          frame_start;
  fss_state_t    state;
  logic [3:0]    div_cnt;
  logic [CW-1:0] shadow_x;
  logic [CW-1:0] shadow_y;
  logic          launch;

  vblank_detect #(
    .H_TOTAL  (H_TOTAL),
    .V_TOTAL  (V_TOTAL),
    .V_ACTIVE (V_ACTIVE)
  ) u_vblank_detect (
    .clk          (clk),
    .reset_n      (reset_n),
    .p_tick       (p_tick),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .vblank_start (vblank_start),
    .frame_start  (frame_start)
  );

  assign launch = vblank_start && (div_cnt == 4'd0) && enable;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt   <= 4'd0;
      frame_cnt <= 16'd0;
    end else begin
      if (vblank_start)
        div_cnt <= (div_cnt == 4'(STEP_DIV - 1)) ? 4'd0 : div_cnt + 4'd1;
      if (frame_start)
        frame_cnt <= frame_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      step_req <= 1'b0;
      overrun  <= 1'b0;
      ball_x   <= CW'(INIT_X);
      ball_y   <= CW'(INIT_Y);
      shadow_x <= '0;
      shadow_y <= '0;
    end else begin
      overrun <= 1'b0;
      unique case (state)
        IDLE: begin
          if (launch) begin
            state    <= REQ;
            step_req <= 1'b1;
          end
        end
        REQ: begin
          // ack beats a simultaneous frame_start
          if (step_ack) begin
            shadow_x <= new_x;
            shadow_y <= new_y;
            step_req <= 1'b0;
            state    <= COMMIT;
          end else if (frame_start) begin
            step_req <= 1'b0;
            overrun  <= 1'b1;
            state    <= IDLE;
          end
        end
        COMMIT: begin
          ball_x <= shadow_x;
          ball_y <= shadow_y;
          state  <= WAIT;
        end
        WAIT: begin
          // engine still holding ack: this vblank's step is lost
          if (step_ack) begin
            if (launch)
              overrun <= 1'b1;
          end else if (launch) begin
            state    <= REQ;
            step_req <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
